// File: rtl/fifo_uart_pkg.sv
// Shared types and line-level constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: pulses bit_done on the last cycle of each bit period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign bit_done = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear || bit_done) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the 16x8 FIFO one byte at a time and sends each byte as an 8N1 frame.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_re,
  output logic       tx,
  output logic       busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic       tx_q, tx_d;
  logic       re_q, busy_q;
  logic       bit_done;

  // Restarting the bit period on every state change keeps START aligned to WAIT's exit edge.
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_d != state_q),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = STOP_BIT;
        if (!fifo_empty) state_d = REQ;
      end
      REQ:  state_d = WAIT;
      WAIT: begin
        shift_d = fifo_data;
        tx_d    = START_BIT;
        state_d = START;
      end
      START: if (bit_done) begin
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (bit_done) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == LAST_BIT) begin
          tx_d    = STOP_BIT;
          state_d = STOP;
        end else begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      STOP: if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      re_q    <= (state_d == REQ);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign fifo_re = re_q;
  assign tx      = tx_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: a CLKS_PER_BIT=4 instance behind a 16x8 FIFO model, plus a CLKS_PER_BIT=2 instance.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, we, hold, empty2;
  logic [7:0] wd, data2;
  logic       re4, tx4, busy4, re2, tx2, busy2;

  logic [7:0] mem [16];
  logic [3:0] wp, rp;
  logic [4:0] cnt;
  logic [7:0] fdout;
  logic       fempty, ffull, empty4_dut;

  assign fempty     = (cnt == 5'd0);
  assign ffull      = (cnt == 5'd16);
  assign empty4_dut = fempty | hold;

  always @(posedge clk) begin
    if (rst) begin
      wp <= '0; rp <= '0; cnt <= '0; fdout <= '0;
    end else begin
      if (we && !ffull) begin mem[wp] <= wd; wp <= wp + 4'd1; end
      if (re4 && !fempty) begin fdout <= mem[rp]; rp <= rp + 4'd1; end
      cnt <= cnt + 5'(we && !ffull) - 5'(re4 && !fempty);
    end
  end

  fifo_uart_tx #(.CLKS_PER_BIT(4)) u4 (
    .clk(clk), .rst(rst), .fifo_empty(empty4_dut), .fifo_data(fdout),
    .fifo_re(re4), .tx(tx4), .busy(busy4)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(2)) u2 (
    .clk(clk), .rst(rst), .fifo_empty(empty2), .fifo_data(data2),
    .fifo_re(re2), .tx(tx2), .busy(busy2)
  );

  int re_cnt4 = 0, re_cnt2 = 0, bad_re = 0;
  always @(negedge clk) begin
    if (re4) re_cnt4++;
    if (re2) re_cnt2++;
    if (re4 && fempty) bad_re++;
  end

  int vecs = 0, miss = 0;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic txs(input bit sel);
    return sel ? tx2 : tx4;
  endfunction

  function automatic logic busys(input bit sel);
    return sel ? busy2 : busy4;
  endfunction

  task automatic wait_low(input bit sel, input int maxc, input string tag, output int n);
    n = 0;
    while (txs(sel) !== 1'b0 && n < maxc) begin tick; n++; end
    chk({tag, " start"}, 32'(txs(sel)), 32'd0);
  endtask

  // Called on the first tx-low sample; returns on the sample after the last stop cycle.
  task automatic frame_check(input bit sel, input int cpb, input logic [7:0] d, input string tag);
    logic [31:0] obs, exp;
    logic        bv;
    for (int b = 0; b < 10; b++) begin
      bv  = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
      obs = '0;
      exp = '0;
      for (int s = 0; s < cpb; s++) begin
        obs[s] = txs(sel);
        exp[s] = bv;
        if (b == 9 && s == cpb - 1) chk($sformatf("%s busy_last", tag), 32'(busys(sel)), 32'd1);
        tick;
      end
      chk($sformatf("%s bit%0d", tag, b), obs, exp);
    end
  endtask

  initial begin
    int base, n, nre, nlow, nbusy;
    rst = 1'b1; we = 1'b0; wd = '0; hold = 1'b0; empty2 = 1'b1; data2 = 8'h81;
    repeat (3) tick;
    chk("rst tx4", 32'(tx4), 32'd1);
    chk("rst re4", 32'(re4), 32'd0);
    chk("rst busy4", 32'(busy4), 32'd0);
    chk("rst tx2", 32'(tx2), 32'd1);
    chk("rst busy2", 32'(busy2), 32'd0);
    rst = 1'b0;
    tick;

    // Single byte 0xA5
    base = re_cnt4;
    we = 1'b1; wd = 8'hA5; tick; we = 1'b0;
    tick;
    chk("a5 req re", 32'(re4), 32'd1);
    chk("a5 req busy", 32'(busy4), 32'd1);
    chk("a5 req tx", 32'(tx4), 32'd1);
    tick;
    chk("a5 wait re", 32'(re4), 32'd0);
    chk("a5 wait tx", 32'(tx4), 32'd1);
    tick;
    chk("a5 lat3", 32'(tx4), 32'd0);
    frame_check(1'b0, 4, 8'hA5, "a5");
    chk("a5 post busy", 32'(busy4), 32'd0);
    chk("a5 post tx", 32'(tx4), 32'd1);
    repeat (5) tick;
    chk("a5 re pulses", 32'(re_cnt4 - base), 32'd1);

    // Back-to-back 0x00, 0xFF
    base = re_cnt4;
    we = 1'b1; wd = 8'h00; tick; wd = 8'hFF; tick; we = 1'b0;
    wait_low(1'b0, 20, "b2b0", n);
    frame_check(1'b0, 4, 8'h00, "b2b0");
    wait_low(1'b0, 20, "b2b1", n);
    chk("b2b gap", 32'(n), 32'd3);
    frame_check(1'b0, 4, 8'hFF, "b2b1");
    repeat (5) tick;
    chk("b2b re pulses", 32'(re_cnt4 - base), 32'd2);
    chk("b2b fifo empty", 32'(fempty), 32'd1);

    // Idle with empty FIFO
    nre = 0; nlow = 0; nbusy = 0;
    repeat (200) begin
      tick;
      if (re4) nre++;
      if (!tx4) nlow++;
      if (busy4) nbusy++;
    end
    chk("idle re", 32'(nre), 32'd0);
    chk("idle txlow", 32'(nlow), 32'd0);
    chk("idle busy", 32'(nbusy), 32'd0);

    // Reset during DATA bit 3 of 0x3C
    we = 1'b1; wd = 8'h3C; tick; we = 1'b0;
    wait_low(1'b0, 20, "r3c", n);
    repeat (9) tick;
    chk("r3c bit1", 32'(tx4), 32'd0);
    repeat (8) tick;
    chk("r3c bit3", 32'(tx4), 32'd1);
    chk("r3c busy", 32'(busy4), 32'd1);
    rst = 1'b1; tick;
    chk("r3c rst tx", 32'(tx4), 32'd1);
    chk("r3c rst busy", 32'(busy4), 32'd0);
    chk("r3c rst re", 32'(re4), 32'd0);
    rst = 1'b0;
    base = re_cnt4;
    repeat (50) tick;
    chk("r3c no re", 32'(re_cnt4 - base), 32'd0);
    chk("r3c idle tx", 32'(tx4), 32'd1);

    // Fill FIFO to full, then drain 16 frames
    hold = 1'b1;
    base = re_cnt4;
    for (int i = 0; i < 16; i++) begin we = 1'b1; wd = 8'(i); tick; end
    we = 1'b0;
    chk("fill full", 32'(ffull), 32'd1);
    chk("fill no re", 32'(re_cnt4 - base), 32'd0);
    hold = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wait_low(1'b0, 60, $sformatf("drain%0d", i), n);
      if (i == 15) chk("drain empty16", 32'(fempty), 32'd1);
      frame_check(1'b0, 4, 8'(i), $sformatf("drain%0d", i));
    end
    repeat (20) tick;
    chk("drain re pulses", 32'(re_cnt4 - base), 32'd16);
    chk("drain idle busy", 32'(busy4), 32'd0);

    // CLKS_PER_BIT=2, byte 0x81
    base = re_cnt2;
    empty2 = 1'b0; tick; empty2 = 1'b1;
    wait_low(1'b1, 10, "c2", n);
    chk("c2 lat", 32'(n), 32'd2);
    frame_check(1'b1, 2, 8'h81, "c2");
    chk("c2 post tx", 32'(tx2), 32'd1);
    chk("c2 post busy", 32'(busy2), 32'd0);
    chk("c2 re pulses", 32'(re_cnt2 - base), 32'd1);

    chk("re while empty", 32'(bad_re), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer for the team's 16x8 synchronous FIFO. It pops bytes through the FIFO read port, honouring its one-cycle registered read latency, and serialises each byte as an 8N1 UART frame on a single output line. It sits between the FIFO and the board TX pin, and is the drain end of the FIFO's write/read interface.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range >= 2.
DATA_BITS, 8, data bits per frame; fixed at 8 to match the FIFO width.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  reset, synchronous, active-high.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  8  FIFO data_out; valid in the cycle after fifo_re was high.
fifo_re  output  1  FIFO read enable; registered, pulses for exactly 1 cycle per byte.
tx  output  1  serial line, registered; idles high.
busy  output  1  high from the REQ cycle through the last stop-bit cycle.

Behaviour:
- Reset values: tx=1, fifo_re=0, busy=0, state=IDLE, all counters 0, shift register 0.
- FSM states: IDLE, REQ, WAIT, START, DATA, STOP.
- IDLE: tx=1. If fifo_empty==0 at the edge, go to REQ.
- REQ: one cycle with fifo_re=1, then go to WAIT. fifo_re is high in no other state.
- WAIT: one cycle. fifo_data is valid here. Capture it into the shift register at the end of the cycle, and on the same edge drive tx=0 and go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Shift right on each bit boundary. The bit counter is 3 bits and leaves DATA when it wraps from 7.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles, from the first tx-low cycle to the last stop cycle.
- Latency: 3 edges from fifo_empty seen low in IDLE to tx first low.
- Back-to-back frames: STOP -> IDLE -> REQ -> WAIT, giving a fixed 3-cycle high gap (IDLE, REQ, WAIT) between the end of one stop bit and the next start bit. No prefetch.
- Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and is cleared on every state entry. It drives the bit_done tick.
- fifo_empty is sampled only in IDLE. Changes in any other state are ignored.
- At most one outstanding read. The block never issues fifo_re while the FIFO is empty.
- Reset mid-frame: on the next edge tx=1, busy=0, state=IDLE. The popped byte is discarded and not retransmitted.
- Reset with rst high during REQ: fifo_re is 0 on the next edge. The FIFO is reset by the same rst, so pointers stay consistent.
- No glitches on tx. Every output is a flop.

Decomposition:
- Package fifo_uart_pkg:
  - state enum (IDLE, REQ, WAIT, START, DATA, STOP);
  - constants START_BIT=1'b0, STOP_BIT=1'b1, DATA_BITS=8.
- Sub-module uart_baud_tick:
  - parameter CLKS_PER_BIT;
  - inputs clk, rst, clear;
  - output bit_done, a 1-cycle pulse when the count reaches CLKS_PER_BIT-1.
  - It is reused later by the matching RX block.

Test Plan:
- Single byte, CLKS_PER_BIT=4. FIFO holds 0xA5; release empty. Required:
  - fifo_re is a single 1-cycle pulse;
  - tx goes low 3 edges later;
  - the line reads 0,1,0,1,0,0,1,0,1,1 (start, LSB-first 0xA5, stop), each bit 4 cycles;
  - busy drops after 40 tx cycles.
- Back-to-back 0x00 then 0xFF. Required: exactly 2 fifo_re pulses, a 3-cycle high gap between frames, and correct bit patterns in both frames.
- FIFO held empty for 200 cycles. Required: fifo_re=0, tx=1 and busy=0 throughout.
- rst asserted in DATA bit 3 of 0x3C. Required: tx=1 and busy=0 on the next edge. After rst deasserts with the FIFO empty, no fifo_re occurs.
- Integration with the 16x8 FIFO: write 16 bytes 0x00..0x0F so full=1, then drain. Required:
  - 16 frames decode to 0x00..0x0F in order;
  - fifo_empty rises after the 16th pop;
  - no further fifo_re.
- CLKS_PER_BIT=2 boundary. Transmit 0x81. Required: each bit lasts exactly 2 cycles, and the frame is 20 cycles long.
